// File: rtl/seq_div_16_if.sv
// ----------------------------------------------------------------------------
// seq_div_16_if
//   Request/result bundle between the execute stage and the sequential divider.
//   Ports (all carried as interface signals):
//     start        request, sampled on the rising clock edge
//     dividend     unsigned numerator, captured when start is accepted
//     divisor      unsigned denominator, captured when start is accepted
//     busy         iterations in progress
//     done         one-cycle completion pulse
//     quotient     dividend / divisor
//     remainder    dividend % divisor
//     div_by_zero  raised with done when the divisor was zero
//   master: the requester (pipeline / testbench); slave: the divider.
// ----------------------------------------------------------------------------
interface seq_div_16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_16.sv
// ----------------------------------------------------------------------------
// seq_div_16
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    seq_div_16_if.slave: start/dividend/divisor in,
//            busy/done/quotient/remainder/div_by_zero out
//   Timing: the accept edge is edge 0; a normal divide completes on edge WIDTH
//   (busy falls, done pulses for one cycle).  A zero divisor completes on
//   edge 1 without ever raising busy.  Results hold until the next completion.
// ----------------------------------------------------------------------------
module seq_div_16 #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_div_16_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // ZDIV is the single non-busy cycle between accepting a zero divisor and
    // presenting the result, so done lands on edge 1 rather than edge 0.
    typedef enum logic [1:0] {IDLE, RUN, ZDIV, FIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_w;      // partial remainder, one guard bit wide
    logic [WIDTH-1:0] quo_w;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo_o;
    logic [WIDTH-1:0] rem_o;
    logic             dbz_o;

    logic             accept;
    logic             last;
    logic [2*WIDTH:0] step;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // One restoring iteration: shift the next dividend bit into the remainder,
    // trial-subtract at full WIDTH+1 width, keep the difference if it did not
    // borrow.  Returns {remainder, quotient}.
    function automatic logic [2*WIDTH:0] div_step(
        input logic [WIDTH:0]   r,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] r_sh;
        logic [WIDTH:0] t;
        r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
        t    = r_sh - {1'b0, d};
        if (!t[WIDTH])
            return {t, q[WIDTH-2:0], 1'b1};
        else
            return {r_sh, q[WIDTH-2:0], 1'b0};
    endfunction

    assign accept  = bus.start && (state == IDLE || state == FIN);
    assign last    = (state == RUN) && (cnt == LAST_CNT);
    assign step    = div_step(rem_w, quo_w, dvs);
    assign rem_nxt = step[2*WIDTH:WIDTH];
    assign quo_nxt = step[WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                if (bus.start)
                    state_nxt = (bus.divisor == '0) ? ZDIV : RUN;
                else if (state == FIN)
                    state_nxt = IDLE;
            end
            RUN:     if (cnt == LAST_CNT) state_nxt = FIN;
            ZDIV:    state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and architectural results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            quo_o <= '0;
            rem_o <= '0;
            dbz_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= '0;
                dbz_o <= 1'b0;
            end else if (state == RUN) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    quo_o <= quo_nxt;
                    rem_o <= rem_nxt[WIDTH-1:0];
                end
            end else if (state == ZDIV) begin
                quo_o <= '1;
                rem_o <= quo_w;   // still holds the captured dividend
                dbz_o <= 1'b1;
            end
        end
    end

    // Working datapath; only meaningful after an accept, so left unreset
    always_ff @(posedge clk) begin
        if (accept) begin
            quo_w <= bus.dividend;
            rem_w <= '0;
            dvs   <= bus.divisor;
        end else if (state == RUN) begin
            quo_w <= quo_nxt;
            rem_w <= rem_nxt;
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == FIN);
    assign bus.quotient    = quo_o;
    assign bus.remainder   = rem_o;
    assign bus.div_by_zero = dbz_o;

endmodule

// File: tb/tb_seq_div_16.sv
// ----------------------------------------------------------------------------
// tb_seq_div_16
//   Scoreboard bench for seq_div_16: expected results are queued when an
//   operation is requested and compared when done is observed.
// ----------------------------------------------------------------------------
module tb_seq_div_16;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_div_16_if #(.WIDTH(WIDTH)) bus ();

    seq_div_16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_q = 16'h0;
    logic [15:0] last_r = 16'h0;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        if (b == 16'h0) begin
            e.q = 16'hFFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
        sb.push_back(model(a, b));
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.q = 16'h0;
            e.r = 16'h0;
            e.z = 1'b0;
        end
        last_q = e.q;
        last_r = e.r;
    endtask

    // Drive a one-cycle request; returns 1 time unit after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
    endtask

    // Advance until done is seen or the budget runs out; lat counts edges.
    task automatic wait_done(input int budget, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!bus.done && lat < budget) begin
            if (bus.busy) bc++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/dbz=%b expected 000",
                     {bus.busy, bus.done, bus.div_by_zero});
        end
        checks++;
        if ({bus.quotient, bus.remainder} !== 32'h0) begin
            errors++;
            $display("FAIL reset_results: got q=%h r=%h expected 0/0",
                     bus.quotient, bus.remainder);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got busy/done=%b expected 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        int   lat, bc;
        exp_t e;
        push_exp(16'd100, 16'd7);
        start_op(16'd100, 16'd7);
        wait_done(40, lat, bc);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL t1_latency: got %0d edges expected 16", lat);
        end
        checks++;
        if (bc !== 16) begin
            errors++;
            $display("FAIL t1_busy_cycles: got %0d expected 16", bc);
        end
        pop_exp(e);
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL t1_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                     bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL t1_done_width: got done=%b one cycle later expected 0", bus.done);
        end
    endtask

    task automatic test_pairs(input string name, input logic [15:0] a0, input logic [15:0] b0,
                              input logic [15:0] a1, input logic [15:0] b1);
        logic [15:0] av[2];
        logic [15:0] bv[2];
        int          lat, bc;
        exp_t        e;
        av[0] = a0; bv[0] = b0; av[1] = a1; bv[1] = b1;
        for (int k = 0; k < 2; k++) begin
            push_exp(av[k], bv[k]);
            start_op(av[k], bv[k]);
            wait_done(40, lat, bc);
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL %s_latency[%0d]: got %0d expected 16", name, k, lat);
            end
            pop_exp(e);
            checks++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.z}) begin
                errors++;
                $display("FAIL %s_result[%0d]: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         name, k, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int   lat, bc;
        exp_t e;
        push_exp(16'h1234, 16'h0000);
        start_op(16'h1234, 16'h0000);
        wait_done(40, lat, bc);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL t4_latency: got %0d edges expected 1", lat);
        end
        checks++;
        if (bc !== 0) begin
            errors++;
            $display("FAIL t4_busy: got %0d busy cycles expected 0", bc);
        end
        pop_exp(e);
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL t4_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                     bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
        end
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b001) begin
            errors++;
            $display("FAIL t4_hold: got busy/done/dbz=%b expected 001",
                     {bus.busy, bus.done, bus.div_by_zero});
        end
        push_exp(16'd9, 16'd3);
        start_op(16'd9, 16'd3);
        checks++;
        if (bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL t4_dbz_clear: got %b after accept expected 0", bus.div_by_zero);
        end
        wait_done(40, lat, bc);
        pop_exp(e);
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.z}) begin
            errors++;
            $display("FAIL t4_next_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                     bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int   lat, bc;
        exp_t e;
        push_exp(16'd100, 16'd7);
        start_op(16'd100, 16'd7);
        for (int k = 0; k < 4; k++) tick();
        // request while busy: must be dropped
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        tick();
        bus.start    = 1'b0;
        wait_done(40, lat, bc);
        checks++;
        if (lat + 5 !== 16) begin
            errors++;
            $display("FAIL t5_latency: got %0d edges expected 16", lat + 5);
        end
        pop_exp(e);
        checks++;
        if ({bus.quotient, bus.remainder} !== {e.q, e.r}) begin
            errors++;
            $display("FAIL t5_ignored_start: got q=%0d r=%0d expected q=%0d r=%0d",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        // request in the done cycle: accepted
        push_exp(16'd50, 16'd5);
        start_op(16'd50, 16'd5);
        checks++;
        if ({bus.done, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL t5_done_drop: got done/busy=%b expected 01", {bus.done, bus.busy});
        end
        wait_done(40, lat, bc);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL t5_second_latency: got %0d expected 16", lat);
        end
        pop_exp(e);
        checks++;
        if ({bus.quotient, bus.remainder} !== {e.q, e.r}) begin
            errors++;
            $display("FAIL t5_second_result: got q=%0d r=%0d expected q=%0d r=%0d",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int   lat, bc, done_seen;
        exp_t e;
        start_op(16'd1000, 16'd3);
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 35'h0) begin
            errors++;
            $display("FAIL t6_abort: got busy=%b done=%b z=%b q=%h r=%h expected all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.done) done_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL t6_no_done: got %0d done cycles expected 0", done_seen);
        end
        last_q = 16'h0;
        last_r = 16'h0;
        push_exp(16'd1000, 16'd3);
        start_op(16'd1000, 16'd3);
        wait_done(40, lat, bc);
        pop_exp(e);
        checks++;
        if ({bus.quotient, bus.remainder} !== {e.q, e.r}) begin
            errors++;
            $display("FAIL t6_result: got q=%0d r=%0d expected q=%0d r=%0d",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_continuous();
        int   lat, bc;
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor  = 16'd9;
        for (int k = 0; k < 3; k++) begin
            push_exp(16'd200, 16'd9);
            tick();
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL cont_done_drop[%0d]: got done=%b expected 0", k, bus.done);
            end
            wait_done(40, lat, bc);
            checks++;
            if (lat + 1 !== WIDTH + 1) begin
                errors++;
                $display("FAIL cont_period[%0d]: got %0d cycles expected %0d", k, lat + 1, WIDTH + 1);
            end
            pop_exp(e);
            checks++;
            if ({bus.quotient, bus.remainder} !== {e.q, e.r}) begin
                errors++;
                $display("FAIL cont_result[%0d]: got q=%0d r=%0d expected q=%0d r=%0d",
                         k, bus.quotient, bus.remainder, e.q, e.r);
            end
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_random(input int n);
        logic [15:0] a, b;
        int          lat, hold_bad, width_bad, lat_bad, res_bad;
        exp_t        e;
        hold_bad = 0; width_bad = 0; lat_bad = 0; res_bad = 0;
        for (int k = 0; k < n; k++) begin
            a = 16'($urandom);
            b = (k % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
            push_exp(a, b);
            start_op(a, b);
            lat = 0;
            while (!bus.done && lat < 40) begin
                if ({bus.quotient, bus.remainder} !== {last_q, last_r}) hold_bad++;
                tick();
                lat++;
            end
            if (lat != 16) lat_bad++;
            pop_exp(e);
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.z}) begin
                res_bad++;
                if (res_bad <= 5)
                    $display("FAIL rand_result: %0d/%0d got q=%0d r=%0d expected q=%0d r=%0d",
                             a, b, bus.quotient, bus.remainder, e.q, e.r);
            end
            tick();
            if (bus.done !== 1'b0) width_bad++;
        end
        checks++;
        if (res_bad !== 0) begin
            errors++;
            $display("FAIL rand_results: got %0d wrong results expected 0", res_bad);
        end
        checks++;
        if (lat_bad !== 0) begin
            errors++;
            $display("FAIL rand_latency: got %0d ops not at 16 edges expected 0", lat_bad);
        end
        checks++;
        if (hold_bad !== 0) begin
            errors++;
            $display("FAIL rand_hold: got %0d cycles of changing outputs expected 0", hold_bad);
        end
        checks++;
        if (width_bad !== 0) begin
            errors++;
            $display("FAIL rand_done_width: got %0d wide done pulses expected 0", width_bad);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = 16'h0;
        bus.divisor  = 16'h0;
        test_reset();
        test_basic();
        test_pairs("t2", 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF);
        test_pairs("t3", 16'd3, 16'd10, 16'h8000, 16'h0003);
        test_div_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_continuous();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
